// File: rtl/archon_entropy_pkg.sv
// Shared types and constants for the entropy throttle controller and its overlay users.
package archon_entropy_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_THROTTLE = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_COOLDOWN = 2'd3
  } ent_state_t;

  localparam logic [1:0] CFG_LO   = 2'd0;
  localparam logic [1:0] CFG_HI   = 2'd1;
  localparam logic [1:0] CFG_CRIT = 2'd2;
  localparam logic [1:0] CFG_CLR  = 2'd3;

  localparam logic [7:0] LO_THRESH_DEF   = 8'h40;
  localparam logic [7:0] HI_THRESH_DEF   = 8'hC0;
  localparam logic [7:0] CRIT_THRESH_DEF = 8'hF0;

endpackage

// File: rtl/entropy_cfg_regs.sv
// Runtime threshold registers with lo < hi <= crit ordering guard and clear strobe.
module entropy_cfg_regs
  import archon_entropy_pkg::*;
#(
  parameter logic [7:0] LO_THRESH_RST   = LO_THRESH_DEF,
  parameter logic [7:0] HI_THRESH_RST   = HI_THRESH_DEF,
  parameter logic [7:0] CRIT_THRESH_RST = CRIT_THRESH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [7:0] lo_thresh,
  output logic [7:0] hi_thresh,
  output logic [7:0] crit_thresh,
  output logic       cfg_err,
  output logic       clr_c
);

  logic [7:0] lo_new_c;
  logic [7:0] hi_new_c;
  logic [7:0] crit_new_c;
  logic       wr_c;
  logic       ok_c;

  assign clr_c = cfg_we && (cfg_addr == CFG_CLR);
  assign wr_c  = cfg_we && (cfg_addr != CFG_CLR);

  // Candidate threshold set as it would look after this write
  always_comb begin
    lo_new_c   = lo_thresh;
    hi_new_c   = hi_thresh;
    crit_new_c = crit_thresh;
    case (cfg_addr)
      CFG_LO:   lo_new_c   = cfg_wdata;
      CFG_HI:   hi_new_c   = cfg_wdata;
      CFG_CRIT: crit_new_c = cfg_wdata;
      default:  ;
    endcase
    ok_c = (lo_new_c < hi_new_c) && (hi_new_c <= crit_new_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_thresh   <= LO_THRESH_RST;
      hi_thresh   <= HI_THRESH_RST;
      crit_thresh <= CRIT_THRESH_RST;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= wr_c && !ok_c;
      if (wr_c && ok_c) begin
        lo_thresh   <= lo_new_c;
        hi_thresh   <= hi_new_c;
        crit_thresh <= crit_new_c;
      end
    end
  end

endmodule

// File: rtl/entropy_throttle_controller.sv
// Entropy-driven pipeline sequencer: hysteretic throttle, flush handshake and cooldown.
module entropy_throttle_controller
  import archon_entropy_pkg::*;
#(
  parameter logic [7:0]  LO_THRESH_RST   = LO_THRESH_DEF,
  parameter logic [7:0]  HI_THRESH_RST   = HI_THRESH_DEF,
  parameter logic [7:0]  CRIT_THRESH_RST = CRIT_THRESH_DEF,
  parameter int unsigned THROTTLE_PERIOD = 4,
  parameter int unsigned COOLDOWN_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] entropy_score_in,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  input  logic       flush_ack,
  output logic       stall_out,
  output logic       flush_req,
  output logic       throttle_active,
  output logic [1:0] state_out,
  output logic [7:0] event_count,
  output logic       cfg_err
);

  localparam int unsigned PHASE_W = 4;
  localparam int unsigned CNT_W   = 8;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(THROTTLE_PERIOD - 1);
  localparam logic [CNT_W-1:0]   CD_LOAD    = CNT_W'(COOLDOWN_CYCLES - 1);

  ent_state_t         state;
  ent_state_t         state_nxt_c;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_nxt_c;
  logic [CNT_W-1:0]   cd_cnt;
  logic [CNT_W-1:0]   cd_nxt_c;
  logic [7:0]         lo_thresh;
  logic [7:0]         hi_thresh;
  logic [7:0]         crit_thresh;
  logic               clr_c;
  logic               crit_hit_c;
  logic               hi_hit_c;
  logic               lo_hit_c;
  logic               flush_entry_c;

  entropy_cfg_regs #(
    .LO_THRESH_RST  (LO_THRESH_RST),
    .HI_THRESH_RST  (HI_THRESH_RST),
    .CRIT_THRESH_RST(CRIT_THRESH_RST)
  ) u_cfg (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .lo_thresh  (lo_thresh),
    .hi_thresh  (hi_thresh),
    .crit_thresh(crit_thresh),
    .cfg_err    (cfg_err),
    .clr_c      (clr_c)
  );

  assign crit_hit_c    = entropy_score_in >= crit_thresh;
  assign hi_hit_c      = entropy_score_in >= hi_thresh;
  assign lo_hit_c      = entropy_score_in <= lo_thresh;
  assign flush_entry_c = (state != ST_FLUSH) && crit_hit_c;
  assign state_out     = 2'(state);

  // Next-state and counter update; FLUSH ignores the score entirely
  always_comb begin
    state_nxt_c = state;
    phase_nxt_c = phase;
    cd_nxt_c    = cd_cnt;
    case (state)
      ST_NORMAL: begin
        if (crit_hit_c) begin
          state_nxt_c = ST_FLUSH;
        end else if (hi_hit_c) begin
          state_nxt_c = ST_THROTTLE;
          phase_nxt_c = '0;
        end
      end
      ST_THROTTLE: begin
        if (crit_hit_c) begin
          state_nxt_c = ST_FLUSH;
        end else if (lo_hit_c) begin
          state_nxt_c = ST_COOLDOWN;
          cd_nxt_c    = CD_LOAD;
        end else begin
          phase_nxt_c = (phase == PHASE_LAST) ? '0 : phase + PHASE_W'(1);
        end
      end
      ST_FLUSH: begin
        if (flush_ack) begin
          state_nxt_c = ST_COOLDOWN;
          cd_nxt_c    = CD_LOAD;
        end
      end
      ST_COOLDOWN: begin
        if (crit_hit_c) begin
          state_nxt_c = ST_FLUSH;
        end else if (cd_cnt == '0) begin
          state_nxt_c = ST_NORMAL;
        end else begin
          cd_nxt_c = cd_cnt - CNT_W'(1);
        end
      end
      default: state_nxt_c = ST_NORMAL;
    endcase
  end

  // Moore outputs are registered from the next state so they align with state_out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_NORMAL;
      phase           <= '0;
      cd_cnt          <= '0;
      stall_out       <= 1'b0;
      flush_req       <= 1'b0;
      throttle_active <= 1'b0;
      event_count     <= '0;
    end else begin
      state           <= state_nxt_c;
      phase           <= phase_nxt_c;
      cd_cnt          <= cd_nxt_c;
      stall_out       <= (state_nxt_c == ST_FLUSH) ||
                         ((state_nxt_c == ST_THROTTLE) && (phase_nxt_c != PHASE_LAST));
      flush_req       <= state_nxt_c == ST_FLUSH;
      throttle_active <= state_nxt_c == ST_THROTTLE;
      if (clr_c) begin
        event_count <= '0;
      end else if (flush_entry_c && (event_count != 8'hFF)) begin
        event_count <= event_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_entropy_throttle_controller.sv
// Directed self-checking bench for entropy_throttle_controller.
module tb_entropy_throttle_controller;

  logic       clk;
  logic       reset;
  logic [7:0] entropy_score_in;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       flush_ack;
  logic       stall_out;
  logic       flush_req;
  logic       throttle_active;
  logic [1:0] state_out;
  logic [7:0] event_count;
  logic       cfg_err;

  int total;
  int bad;

  entropy_throttle_controller dut (
    .clk             (clk),
    .reset           (reset),
    .entropy_score_in(entropy_score_in),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_wdata       (cfg_wdata),
    .flush_ack       (flush_ack),
    .stall_out       (stall_out),
    .flush_req       (flush_req),
    .throttle_active (throttle_active),
    .state_out       (state_out),
    .event_count     (event_count),
    .cfg_err         (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic wait_normal();
    entropy_score_in = 8'h10;
    for (int i = 0; i < 40 && state_out != 2'd0; i++) step();
    total++; if (state_out !== 2'd0) begin bad++; $display("FAIL wait_normal state got=%0d exp=0", state_out); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    entropy_score_in = 8'h10;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00; flush_ack = 1'b0;
    repeat (2) step();
    total++; if (state_out !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state_out); end
    total++; if ({stall_out, flush_req, throttle_active, cfg_err} !== 4'b0000) begin bad++; $display("FAIL rst_outs got=%b exp=0000", {stall_out, flush_req, throttle_active, cfg_err}); end
    reset = 1'b0;
    repeat (20) step();
    total++; if (state_out !== 2'd0) begin bad++; $display("FAIL idle_state got=%0d exp=0", state_out); end
    total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL idle_stall got=%b exp=0", stall_out); end
    total++; if (event_count !== 8'd0) begin bad++; $display("FAIL idle_evt got=%0d exp=0", event_count); end
  endtask

  task automatic test_throttle();
    logic exp_stall;
    entropy_score_in = 8'hC0;
    step();
    total++; if (state_out !== 2'd1) begin bad++; $display("FAIL thr_enter got=%0d exp=1", state_out); end
    total++; if (throttle_active !== 1'b1) begin bad++; $display("FAIL thr_active got=%b exp=1", throttle_active); end
    for (int i = 0; i < 8; i++) begin
      exp_stall = (i % 4) != 3;
      total++; if (stall_out !== exp_stall) begin bad++; $display("FAIL thr_stall[%0d] got=%b exp=%b", i, stall_out, exp_stall); end
      if (i < 7) step();
    end
    entropy_score_in = 8'h40;
    step();
    total++; if (state_out !== 2'd3) begin bad++; $display("FAIL cd_enter got=%0d exp=3", state_out); end
    total++; if ({stall_out, throttle_active} !== 2'b00) begin bad++; $display("FAIL cd_outs got=%b exp=00", {stall_out, throttle_active}); end
    entropy_score_in = 8'h10;
    repeat (15) step();
    total++; if (state_out !== 2'd3) begin bad++; $display("FAIL cd_hold15 got=%0d exp=3", state_out); end
    step();
    total++; if (state_out !== 2'd0) begin bad++; $display("FAIL cd_exit16 got=%0d exp=0", state_out); end
  endtask

  task automatic test_flush();
    entropy_score_in = 8'hF5;
    step();
    total++; if (state_out !== 2'd2) begin bad++; $display("FAIL fl_state got=%0d exp=2", state_out); end
    total++; if ({flush_req, stall_out} !== 2'b11) begin bad++; $display("FAIL fl_outs got=%b exp=11", {flush_req, stall_out}); end
    total++; if (event_count !== 8'd1) begin bad++; $display("FAIL fl_evt got=%0d exp=1", event_count); end
    entropy_score_in = 8'h10;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (flush_req !== 1'b1) begin bad++; $display("FAIL fl_hold[%0d] got=%b exp=1", i, flush_req); end
    end
    flush_ack = 1'b1;
    step();
    flush_ack = 1'b0;
    total++; if (state_out !== 2'd3) begin bad++; $display("FAIL fl_ack_state got=%0d exp=3", state_out); end
    total++; if (flush_req !== 1'b0) begin bad++; $display("FAIL fl_ack_req got=%b exp=0", flush_req); end
  endtask

  task automatic test_cooldown_hysteresis();
    entropy_score_in = 8'hD0;
    repeat (5) step();
    total++; if (state_out !== 2'd3) begin bad++; $display("FAIL hyst_state got=%0d exp=3", state_out); end
    // Ack raised on the FLUSH entry edge must not be honoured
    entropy_score_in = 8'hF8;
    flush_ack = 1'b1;
    step();
    total++; if (state_out !== 2'd2) begin bad++; $display("FAIL cd_crit_state got=%0d exp=2", state_out); end
    total++; if (event_count !== 8'd2) begin bad++; $display("FAIL cd_crit_evt got=%0d exp=2", event_count); end
    total++; if (flush_req !== 1'b1) begin bad++; $display("FAIL entry_ack_req got=%b exp=1", flush_req); end
    step();
    flush_ack = 1'b0;
    total++; if (state_out !== 2'd3) begin bad++; $display("FAIL ack2_state got=%0d exp=3", state_out); end
    wait_normal();
  endtask

  task automatic test_cfg();
    cfg_write(2'd1, 8'h30);
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_bad_err got=%b exp=1", cfg_err); end
    step();
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_pulse got=%b exp=0", cfg_err); end
    entropy_score_in = 8'h80;
    repeat (3) step();
    total++; if (state_out !== 2'd0) begin bad++; $display("FAIL cfg_hi_kept got=%0d exp=0", state_out); end
    // Write hi=0x70 with score 0x80 on the same edge: old hi still applies there
    cfg_write(2'd1, 8'h70);
    total++; if ({cfg_err, state_out} !== 3'b000) begin bad++; $display("FAIL cfg_same_edge got=%b exp=000", {cfg_err, state_out}); end
    step();
    total++; if (state_out !== 2'd1) begin bad++; $display("FAIL cfg_new_hi got=%0d exp=1", state_out); end
    wait_normal();
    cfg_write(2'd1, 8'hC0);
    cfg_write(2'd2, 8'hC0);
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_hi_eq_crit got=%b exp=0", cfg_err); end
    cfg_write(2'd2, 8'hBF);
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_crit_lt_hi got=%b exp=1", cfg_err); end
    cfg_write(2'd2, 8'hF0);
    cfg_write(2'd3, 8'h55);
    total++; if (event_count !== 8'd0) begin bad++; $display("FAIL cfg_clear got=%0d exp=0", event_count); end
    // Clear coincident with FLUSH entry
    entropy_score_in = 8'hF5;
    cfg_write(2'd3, 8'h00);
    total++; if ({state_out, event_count} !== {2'd2, 8'd0}) begin bad++; $display("FAIL clr_vs_flush got=%h exp=200", {state_out, event_count}); end
    entropy_score_in = 8'h10;
    flush_ack = 1'b1;
    step();
    flush_ack = 1'b0;
    wait_normal();
  endtask

  task automatic test_reset_mid_flush();
    entropy_score_in = 8'hF5;
    step();
    total++; if (state_out !== 2'd2) begin bad++; $display("FAIL mid_pre got=%0d exp=2", state_out); end
    #1 reset = 1'b1;
    #1;
    total++; if ({flush_req, stall_out, state_out} !== 4'b0000) begin bad++; $display("FAIL mid_async got=%b exp=0000", {flush_req, stall_out, state_out}); end
    entropy_score_in = 8'h10;
    step();
    reset = 1'b0;
    step();
    total++; if ({state_out, event_count} !== {2'd0, 8'd0}) begin bad++; $display("FAIL mid_after got=%h exp=000", {state_out, event_count}); end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 258; i++) begin
      entropy_score_in = 8'hF5;
      step();
      if (i == 255) begin
        total++; if (event_count !== 8'hFF) begin bad++; $display("FAIL sat_255 got=%h exp=ff", event_count); end
      end
      if (i == 256) begin
        total++; if (event_count !== 8'hFF) begin bad++; $display("FAIL sat_256 got=%h exp=ff", event_count); end
      end
      flush_ack = 1'b1;
      step();
      flush_ack = 1'b0;
    end
    total++; if (event_count !== 8'hFF) begin bad++; $display("FAIL sat_end got=%h exp=ff", event_count); end
    wait_normal();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_throttle();
    test_flush();
    test_cooldown_hysteresis();
    test_cfg();
    test_reset_mid_flush();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
